// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbitration: merges stage stalls, picks trap/EX/ID redirects,
// holds a redirect across a frozen PC, and drives stage flushes.
module pc_redirect_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             mem_stall_req,
  input  logic             trap_redir_ena,
  input  logic [PC_W-1:0]  trap_redir_pc,
  input  logic             ex_redir_ena,
  input  logic [PC_W-1:0]  ex_redir_pc,
  input  logic             id_redir_ena,
  input  logic [PC_W-1:0]  id_redir_pc,
  output logic [4:0]       stall_ctrl,
  output logic             pc_redir_ena,
  output logic [PC_W-1:0]  pc_redir_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ID   = 2'd1;
  localparam logic [1:0] SRC_EX   = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  state_e            state_q, state_d;
  logic [1:0]        pend_src_q, pend_src_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;

  logic              pc_stalled;
  logic [1:0]        win_src;
  logic [PC_W-1:0]   win_pc;
  logic [1:0]        iss_src;
  logic [PC_W-1:0]   iss_pc;

  always_comb begin
    stall_ctrl = 5'b00000;
    if (if_stall_req)  stall_ctrl = stall_ctrl | 5'b00011;
    if (id_stall_req)  stall_ctrl = stall_ctrl | 5'b00111;
    if (mem_stall_req) stall_ctrl = stall_ctrl | 5'b11111;
  end

  assign pc_stalled = stall_ctrl[0];

  always_comb begin
    win_src = SRC_NONE;
    win_pc  = '0;
    if (trap_redir_ena) begin
      win_src = SRC_TRAP;
      win_pc  = trap_redir_pc;
    end else if (ex_redir_ena) begin
      win_src = SRC_EX;
      win_pc  = ex_redir_pc;
    end else if (id_redir_ena) begin
      win_src = SRC_ID;
      win_pc  = id_redir_pc;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_src_d = pend_src_q;
    pend_pc_d  = pend_pc_q;
    iss_src    = SRC_NONE;
    iss_pc     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_src != SRC_NONE) begin
          if (!pc_stalled) begin
            iss_src = win_src;
            iss_pc  = win_pc;
          end else begin
            state_d    = PEND;
            pend_src_d = win_src;
            pend_pc_d  = win_pc;
          end
        end
      end
      PEND: begin
        if (pc_stalled) begin
          // equal/lower priority arrivals are on the wrong path
          if (win_src > pend_src_q) begin
            pend_src_d = win_src;
            pend_pc_d  = win_pc;
          end
        end else begin
          state_d    = IDLE;
          pend_src_d = SRC_NONE;
          if (win_src > pend_src_q) begin
            iss_src = win_src;
            iss_pc  = win_pc;
          end else begin
            iss_src = pend_src_q;
            iss_pc  = pend_pc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      iss_src = SRC_NONE;
      iss_pc  = '0;
    end
  end

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    if (iss_src != SRC_NONE && redir_cnt_q != {CNT_W{1'b1}})
      redir_cnt_d = redir_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_src_q  <= SRC_NONE;
      pend_pc_q   <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_src_q  <= pend_src_d;
      pend_pc_q   <= pend_pc_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign pc_redir_ena = iss_src != SRC_NONE;
  assign pc_redir_pc  = iss_pc;
  assign flush_if_id  = iss_src != SRC_NONE;
  assign flush_id_ex  = iss_src == SRC_EX || iss_src == SRC_TRAP;
  assign flush_ex_mem = iss_src == SRC_TRAP;
  assign redir_cnt    = redir_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed cycles push expected
// outputs, which are popped and compared mid-cycle.
module tb_pc_redirect_ctrl;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;

  typedef struct {
    logic [4:0]       st;
    logic             ena;
    logic [PC_W-1:0]  pc;
    logic [2:0]       fl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_stall_req, id_stall_req, mem_stall_req;
  logic             trap_redir_ena, ex_redir_ena, id_redir_ena;
  logic [PC_W-1:0]  trap_redir_pc, ex_redir_pc, id_redir_pc;
  logic [4:0]       stall_ctrl;
  logic             pc_redir_ena;
  logic [PC_W-1:0]  pc_redir_pc;
  logic             flush_if_id, flush_id_ex, flush_ex_mem;
  logic [CNT_W-1:0] redir_cnt;

  int               n_chk = 0;
  int               n_fail = 0;
  exp_t             sb_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .mem_stall_req(mem_stall_req),
    .trap_redir_ena(trap_redir_ena), .trap_redir_pc(trap_redir_pc),
    .ex_redir_ena(ex_redir_ena), .ex_redir_pc(ex_redir_pc),
    .id_redir_ena(id_redir_ena), .id_redir_pc(id_redir_pc),
    .stall_ctrl(stall_ctrl), .pc_redir_ena(pc_redir_ena),
    .pc_redir_pc(pc_redir_pc), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .redir_cnt(redir_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // st_req = {mem,id,if}, en = {trap,ex,id}, e_fl = {ex_mem,id_ex,if_id}
  task automatic drive(input logic [2:0] st_req, input logic [2:0] en,
                       input logic [63:0] tpc, input logic [63:0] epc,
                       input logic [63:0] ipc);
    {mem_stall_req, id_stall_req, if_stall_req} = st_req;
    {trap_redir_ena, ex_redir_ena, id_redir_ena} = en;
    trap_redir_pc = tpc;
    ex_redir_pc   = epc;
    id_redir_pc   = ipc;
  endtask

  function automatic logic [4:0] stall_of(input logic [2:0] s);
    if (s[2]) return 5'b11111;
    if (s[1]) return 5'b00111;
    if (s[0]) return 5'b00011;
    return 5'b00000;
  endfunction

  task automatic push(input logic [2:0] st_req, input logic e_ena,
                      input logic [63:0] e_pc, input logic [2:0] e_fl);
    exp_t e;
    e.st  = stall_of(st_req);
    e.ena = e_ena;
    e.pc  = e_pc;
    e.fl  = e_fl;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (e_ena && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("stall_ctrl", {59'd0, stall_ctrl}, {59'd0, e.st});
    chk("pc_redir_ena", {63'd0, pc_redir_ena}, {63'd0, e.ena});
    chk("pc_redir_pc", pc_redir_pc, e.pc);
    chk("flush", {61'd0, flush_ex_mem, flush_id_ex, flush_if_id},
        {61'd0, e.fl});
    chk("redir_cnt", {60'd0, redir_cnt}, {60'd0, e.cnt});
  endtask

  task automatic step(input logic [2:0] st_req, input logic [2:0] en,
                      input logic [63:0] tpc, input logic [63:0] epc,
                      input logic [63:0] ipc, input logic e_ena,
                      input logic [63:0] e_pc, input logic [2:0] e_fl);
    @(negedge clk);
    drive(st_req, en, tpc, epc, ipc);
    push(st_req, e_ena, e_pc, e_fl);
    #2;
    compare();
  endtask

  task automatic idle();
    step(3'b000, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 3'b000, 0, 0, 0);
    idle();
    rst = 1'b0;
    idle();

    // unstalled EX redirect, zero latency
    step(3'b000, 3'b010, 0, 64'h8000_0100, 0, 1'b1, 64'h8000_0100, 3'b011);
    idle();

    // ID jump held across three MEM stall cycles
    step(3'b100, 3'b001, 0, 0, 64'h8000_0040, 1'b0, 0, 3'b000);
    step(3'b100, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
    step(3'b100, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
    step(3'b000, 3'b000, 0, 0, 0, 1'b1, 64'h8000_0040, 3'b001);
    idle();

    // pending EX overwritten by trap, later ID ignored
    step(3'b100, 3'b010, 0, 64'h100, 0, 1'b0, 0, 3'b000);
    step(3'b100, 3'b100, 64'h200, 0, 0, 1'b0, 0, 3'b000);
    step(3'b100, 3'b001, 0, 0, 64'h300, 1'b0, 0, 3'b000);
    step(3'b000, 3'b000, 0, 0, 0, 1'b1, 64'h200, 3'b111);
    idle();

    // pending EX beats lower ID, both while stalled and on release
    step(3'b100, 3'b010, 0, 64'h100, 0, 1'b0, 0, 3'b000);
    step(3'b100, 3'b001, 0, 0, 64'h300, 1'b0, 0, 3'b000);
    step(3'b000, 3'b001, 0, 0, 64'h300, 1'b1, 64'h100, 3'b011);
    idle();

    // equal-priority arrival on release does not replace pending
    step(3'b010, 3'b010, 0, 64'h100, 0, 1'b0, 0, 3'b000);
    step(3'b000, 3'b010, 0, 64'h999, 0, 1'b1, 64'h100, 3'b011);

    // strictly higher arrival on release wins
    step(3'b001, 3'b001, 0, 0, 64'h40, 1'b0, 0, 3'b000);
    step(3'b000, 3'b100, 64'h200, 0, 0, 1'b1, 64'h200, 3'b111);

    // simultaneous requests unstalled
    step(3'b000, 3'b111, 64'hAAA, 64'hBBB, 64'hCCC, 1'b1, 64'hAAA, 3'b111);
    idle();

    // stall merging
    step(3'b011, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
    step(3'b001, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
    step(3'b010, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);
    step(3'b101, 3'b000, 0, 0, 0, 1'b0, 0, 3'b000);

    // async reset during PEND discards the held redirect
    step(3'b100, 3'b010, 0, 64'h700, 0, 1'b0, 0, 3'b000);
    @(negedge clk);
    drive(3'b100, 3'b000, 0, 0, 0);
    #1 rst = 1'b1;
    exp_cnt = '0;
    push(3'b100, 1'b0, 0, 3'b000);
    #1 compare();
    #1 rst = 1'b0;
    idle();
    idle();

    // saturating counter
    for (int i = 0; i < 18; i++)
      step(3'b000, 3'b001, 0, 0, 64'(i + 16), 1'b1, 64'(i + 16), 3'b001);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
